// File: rtl/detect_event_display.sv
// detect_event_display
//
// Purpose:
//   Consumes the 4-bit z output of the serial sequence detector.
//   Each new detection (rising edge of "z is nonzero") counts once.
//   Events are counted in 2-digit BCD (00-99), with a sticky wrap flag.
//   The count is shown on a time-multiplexed, active-low 2-digit
//   7-segment display.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous, active-high reset
//   z      in   4  detector output; nonzero means "detected"
//   clr    in   1  synchronous clear of count and ovf; wins over an event
//   count  out  8  registered BCD count {tens, ones}
//   ovf    out  1  registered sticky wrap flag (99 -> 00)
//   an     out  2  active-low digit enables; an[0]=ones, an[1]=tens
//   seg    out  7  active-low segments g,f,e,d,c,b,a
module detect_event_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] z,
  input  logic       clr,
  output logic [7:0] count,
  output logic       ovf,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int               DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic             r_zprev;
  logic [7:0]       r_count;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic             r_sel;

  logic             w_nz;
  logic             w_event;
  logic [3:0]       w_nib;

  assign w_nz    = |z;
  // Only the 0 -> nonzero transition is an event; changes between two
  // nonzero codes are the same ongoing detection.
  assign w_event = w_nz & ~r_zprev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zprev <= 1'b0;
    end else begin
      r_zprev <= w_nz;
    end
  end

  // BCD counter. clr takes precedence over a coincident event; r_zprev
  // still tracks z, so a z held across the clr edge does not count later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'h00;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= 8'h00;
      r_ovf   <= 1'b0;
    end else if (w_event) begin
      if (r_count == 8'h99) begin
        r_count <= 8'h00;
        r_ovf   <= 1'b1;
      end else if (r_count[3:0] == 4'd9) begin
        r_count <= {r_count[7:4] + 4'd1, 4'd0};
      end else begin
        r_count <= {r_count[7:4], r_count[3:0] + 4'd1};
      end
    end
  end

  // Digit scan: free-running, independent of clr and events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_sel <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_nib = r_sel ? r_count[7:4] : r_count[3:0];

  assign count = r_count;
  assign ovf   = r_ovf;
  // Exactly one digit is enabled at any time.
  assign an    = r_sel ? 2'b01 : 2'b10;
  assign seg   = seg_decode(w_nib);

endmodule

// File: tb/tb_detect_event_display.sv
module tb_detect_event_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] z;
  logic       clr;
  logic [7:0] count;
  logic       ovf;
  logic [1:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, not the RTL encoding.
  int m_cnt;
  bit m_ovf;
  bit m_prev;
  int m_cyc;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  detect_event_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .z     (z),
    .clr   (clr),
    .count (count),
    .ovf   (ovf),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_count();
    return {4'(m_cnt / 10), 4'(m_cnt % 10)};
  endfunction

  function automatic bit exp_sel();
    return ((m_cyc / SCAN_DIV) % 2) == 1;
  endfunction

  function automatic logic [1:0] exp_an();
    return exp_sel() ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg();
    return seg_tab[exp_sel() ? (m_cnt / 10) : (m_cnt % 10)];
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    m_cyc  = 0;
  endtask

  // Drive one clock cycle and advance the model; returns 1 ns after the edge.
  task automatic tick(input logic [3:0] zz, input logic cc);
    bit nz;
    z   = zz;
    clr = cc;
    @(posedge clk);
    nz = (zz != 4'd0);
    if (cc) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (nz && !m_prev) begin
      if (m_cnt == 99) begin
        m_cnt = 0;
        m_ovf = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_prev = nz;
    m_cyc  = m_cyc + 1;
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick(4'($urandom_range(1, 15)), 1'b0);
      tick(4'd0, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    z     = 4'd0;
    clr   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h exp=00", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (an !== 2'b10) begin bad++; $display("FAIL reset_an got=%b exp=10", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(4'd0, 1'b0);
      total++; if (count !== 8'h00) begin bad++; $display("FAIL idle_count cyc=%0d got=%h exp=00", i, count); end
      total++; if (an !== exp_an()) begin bad++; $display("FAIL idle_an cyc=%0d got=%b exp=%b", i, an, exp_an()); end
      total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL idle_seg cyc=%0d got=%b exp=1000000", i, seg); end
    end
  endtask

  task automatic test_pulses();
    logic [7:0] want;
    for (int i = 1; i <= 3; i++) begin
      tick(4'b0001, 1'b0);
      want = 8'(i);
      total++; if (count !== want) begin bad++; $display("FAIL pulse_count n=%0d got=%h exp=%h", i, count, want); end
      repeat (3) tick(4'd0, 1'b0);
    end
  endtask

  task automatic test_hold();
    tick(4'd0, 1'b1);
    repeat (5) tick(4'b0001, 1'b0);
    repeat (3) tick(4'b0010, 1'b0);
    tick(4'd0, 1'b0);
    total++; if (count !== 8'h01) begin bad++; $display("FAIL hold_count got=%h exp=01", count); end
    total++; if (count !== exp_count()) begin bad++; $display("FAIL hold_model got=%h exp=%h", count, exp_count()); end
  endtask

  task automatic test_wrap();
    int guard;
    tick(4'd0, 1'b1);
    pulses(99);
    total++; if (count !== 8'h99) begin bad++; $display("FAIL wrap99_count got=%h exp=99", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL wrap99_ovf got=%b exp=0", ovf); end
    guard = 0;
    while (!exp_sel() && guard < 2 * SCAN_DIV) begin
      tick(4'd0, 1'b0);
      guard++;
    end
    total++; if (an !== 2'b01) begin bad++; $display("FAIL wrap99_an got=%b exp=01", an); end
    total++; if (seg !== 7'b0010000) begin bad++; $display("FAIL wrap99_seg got=%b exp=0010000", seg); end
    pulses(1);
    total++; if (count !== 8'h00) begin bad++; $display("FAIL wrap_count got=%h exp=00", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_clr();
    pulses(42);
    total++; if (count !== 8'h42 || ovf !== 1'b1) begin bad++; $display("FAIL pre_clr got=%h/%b exp=42/1", count, ovf); end
    tick(4'b0100, 1'b1);
    total++; if (count !== 8'h00 || ovf !== 1'b0) begin bad++; $display("FAIL clr got=%h/%b exp=00/0", count, ovf); end
    tick(4'b1000, 1'b0);
    total++; if (count !== 8'h00) begin bad++; $display("FAIL clr_held_z got=%h exp=00", count); end
    tick(4'd0, 1'b0);
    tick(4'b0001, 1'b0);
    total++; if (count !== 8'h01) begin bad++; $display("FAIL post_clr got=%h exp=01", count); end
  endtask

  task automatic test_async_reset();
    tick(4'd0, 1'b1);
    pulses(17);
    total++; if (count !== 8'h17) begin bad++; $display("FAIL pre_areset got=%h exp=17", count); end
    z = 4'b0001;
    #3;
    reset = 1'b1;
    #1;
    total++; if (count !== 8'h00) begin bad++; $display("FAIL areset_count got=%h exp=00", count); end
    total++; if (an !== 2'b10) begin bad++; $display("FAIL areset_an got=%b exp=10", an); end
    total++; if (ovf !== 1'b0 || seg !== 7'b1000000) begin bad++; $display("FAIL areset_ovf_seg got=%b/%b exp=0/1000000", ovf, seg); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick(4'b0001, 1'b0);
    total++; if (count !== 8'h01) begin bad++; $display("FAIL areset_first_edge got=%h exp=01", count); end
  endtask

  task automatic test_random();
    logic [3:0] zz;
    logic       cc;
    zz = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0)
        zz = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cc = ($urandom_range(0, 39) == 0);
      tick(zz, cc);
      total++;
      if (count !== exp_count() || ovf !== m_ovf || an !== exp_an() || seg !== exp_seg()) begin
        bad++;
        $display("FAIL random i=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", i, count, ovf, an, seg,
                 exp_count(), m_ovf, exp_an(), exp_seg());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pulses();
    test_hold();
    test_wrap();
    test_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
